// File: rtl/multichannel_level_meter.sv
// multichannel_level_meter
//   Multi-channel audio level detector. Accepts a time-multiplexed stream of
//   signed PCM samples tagged with a channel index. For each channel it keeps
//   the section peak magnitude, a decaying bar and a held peak marker. It
//   publishes one packed LED array for all channels through a valid/ready
//   handshake.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   i_valid    : sample valid
//   i_ready    : sample accepted on i_valid && i_ready (low during UPDATE)
//   i_channel  : channel index of the sample; indices >= channels are dropped
//   i_value    : signed two's-complement sample
//   o_valid    : o_array holds a snapshot
//   o_ready    : downstream accepts the snapshot on o_valid && o_ready
//   o_array    : channel c LEDs at [c*indicator_width +: indicator_width]
module multichannel_level_meter #(
   parameter int channels             = 2,
   parameter int sample_width         = 16,
   parameter int indicator_width      = 32,
   parameter int section_sample_count = 31,
   parameter int hold_sections        = 32,
   localparam int CW = (channels > 1) ? $clog2(channels) : 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                i_valid,
   output logic                                i_ready,
   input  logic [CW-1:0]                       i_channel,
   input  logic signed [sample_width-1:0]      i_value,
   output logic                                o_valid,
   input  logic                                o_ready,
   output logic [channels*indicator_width-1:0] o_array
);

   localparam int MW  = sample_width - 1;
   localparam int PW  = MW + $clog2(indicator_width) + 1;
   localparam int LW  = $clog2(indicator_width + 1);
   localparam int HW  = (hold_sections > 0) ? $clog2(hold_sections + 1) : 1;
   localparam int SCW = (section_sample_count > 1) ? $clog2(section_sample_count) : 1;
   localparam int OW  = channels * indicator_width;
   localparam logic [CW:0] CH_LIM = (CW + 1)'(channels);

   typedef enum logic {ACCUM, UPDATE} state_t;

   // |v|; the most negative code has no positive twin and saturates.
   function automatic logic [MW-1:0] magnitude(input logic signed [sample_width-1:0] v);
      logic [sample_width-1:0] neg;
      neg = ~v + 1'b1;
      if (!v[sample_width-1])     magnitude = v[MW-1:0];
      else if (neg[sample_width-1]) magnitude = '1;
      else                        magnitude = neg[MW-1:0];
   endfunction

   // Scale a section maximum to an LED count, clamped to the bar length.
   function automatic logic [LW-1:0] level_of(input logic [MW-1:0] m);
      logic [PW-1:0] prod;
      logic [PW-1:0] sh;
      prod = PW'(m) * PW'(indicator_width);
      sh   = prod >> MW;
      if (sh > PW'(indicator_width)) level_of = LW'(indicator_width);
      else                           level_of = LW'(sh);
   endfunction

   state_t          state_q, state_d;
   logic [MW-1:0]   sec_max_q [channels];
   logic [MW-1:0]   sec_max_d [channels];
   logic [SCW-1:0]  sec_cnt_q [channels];
   logic [SCW-1:0]  sec_cnt_d [channels];
   logic [LW-1:0]   bar_q     [channels];
   logic [LW-1:0]   bar_d     [channels];
   logic [LW-1:0]   peak_q    [channels];
   logic [LW-1:0]   peak_d    [channels];
   logic [HW-1:0]   hold_q    [channels];
   logic [HW-1:0]   hold_d    [channels];
   logic [CW-1:0]   lat_ch_q, lat_ch_d;
   logic [MW-1:0]   lat_max_q, lat_max_d;
   logic            pending_q, pending_d;
   logic            o_valid_q, o_valid_d;
   logic [OW-1:0]   o_array_q, o_array_d;

   logic [MW-1:0]   mag_in;
   logic [MW-1:0]   cur_max;
   logic [LW-1:0]   lvl;
   logic [LW-1:0]   bar_new;
   logic            acc;
   logic            upd;
   logic            load;
   logic [OW-1:0]   snap;

   assign i_ready = (state_q == ACCUM);
   assign mag_in  = magnitude(i_value);
   assign acc     = i_valid && (state_q == ACCUM) && ({1'b0, i_channel} < CH_LIM);

   always_comb begin
      state_d   = state_q;
      sec_max_d = sec_max_q;
      sec_cnt_d = sec_cnt_q;
      bar_d     = bar_q;
      peak_d    = peak_q;
      hold_d    = hold_q;
      lat_ch_d  = lat_ch_q;
      lat_max_d = lat_max_q;
      cur_max   = '0;
      lvl       = '0;
      bar_new   = '0;
      upd       = 1'b0;
      case (state_q)
         ACCUM: begin
            if (acc) begin
               cur_max = (mag_in > sec_max_q[i_channel]) ? mag_in : sec_max_q[i_channel];
               sec_max_d[i_channel] = cur_max;
               if (sec_cnt_q[i_channel] == SCW'(section_sample_count - 1)) begin
                  // Section complete: hand the final max to the one-cycle update.
                  sec_cnt_d[i_channel] = '0;
                  lat_ch_d  = i_channel;
                  lat_max_d = cur_max;
                  state_d   = UPDATE;
               end else begin
                  sec_cnt_d[i_channel] = sec_cnt_q[i_channel] + 1'b1;
               end
            end
         end
         UPDATE: begin
            lvl     = level_of(lat_max_q);
            bar_new = (lvl >= bar_q[lat_ch_q]) ? lvl : bar_q[lat_ch_q] - 1'b1;
            bar_d[lat_ch_q] = bar_new;
            if (lvl >= peak_q[lat_ch_q]) begin
               peak_d[lat_ch_q] = lvl;
               hold_d[lat_ch_q] = HW'(hold_sections);
            end else if (hold_q[lat_ch_q] != '0) begin
               hold_d[lat_ch_q] = hold_q[lat_ch_q] - 1'b1;
            end else begin
               // Falling marker never drops below the bar it sits on.
               peak_d[lat_ch_q] = (bar_new > peak_q[lat_ch_q] - 1'b1) ?
                                  bar_new : peak_q[lat_ch_q] - 1'b1;
            end
            sec_max_d[lat_ch_q] = '0;
            upd     = 1'b1;
            state_d = ACCUM;
         end
      endcase
   end

   // LED image: bar filled from bit 0, plus a single marker bit for the peak.
   always_comb begin
      snap = '0;
      for (int c = 0; c < channels; c++) begin
         for (int k = 0; k < indicator_width; k++) begin
            if ((LW'(k) < bar_q[c]) || ((peak_q[c] != '0) && (LW'(k + 1) == peak_q[c])))
               snap[c*indicator_width + k] = 1'b1;
         end
      end
   end

   // An update landing in the load cycle re-arms pending so it is not lost.
   always_comb begin
      load      = pending_q && (!o_valid_q || o_ready);
      pending_d = load ? upd : (pending_q || upd);
      o_valid_d = load ? 1'b1 : (o_ready ? 1'b0 : o_valid_q);
      o_array_d = load ? snap : o_array_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ACCUM;
         lat_ch_q  <= '0;
         lat_max_q <= '0;
         pending_q <= 1'b0;
         o_valid_q <= 1'b0;
         o_array_q <= '0;
         for (int c = 0; c < channels; c++) begin
            sec_max_q[c] <= '0;
            sec_cnt_q[c] <= '0;
            bar_q[c]     <= '0;
            peak_q[c]    <= '0;
            hold_q[c]    <= '0;
         end
      end else begin
         state_q   <= state_d;
         lat_ch_q  <= lat_ch_d;
         lat_max_q <= lat_max_d;
         pending_q <= pending_d;
         o_valid_q <= o_valid_d;
         o_array_q <= o_array_d;
         sec_max_q <= sec_max_d;
         sec_cnt_q <= sec_cnt_d;
         bar_q     <= bar_d;
         peak_q    <= peak_d;
         hold_q    <= hold_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_array = o_array_q;

endmodule

// File: tb/tb_multichannel_level_meter.sv
// Self-checking bench for multichannel_level_meter (3 channels, 16-bit PCM,
// 32 LEDs, 31-sample sections, 32-section hold).
module tb_multichannel_level_meter;

   localparam int CH = 3;
   localparam int SW = 16;
   localparam int IW = 32;
   localparam int NS = 31;
   localparam int HS = 32;
   localparam int OW = CH * IW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 i_valid;
   logic                 i_ready;
   logic [1:0]           i_channel;
   logic signed [SW-1:0] i_value;
   logic                 o_valid;
   logic                 o_ready;
   logic [OW-1:0]        o_array;

   int errors = 0;
   int checks = 0;

   // Reference state, one entry per legal channel
   int m_max  [CH];
   int m_cnt  [CH];
   int m_bar  [CH];
   int m_peak [CH];
   int m_hold [CH];

   multichannel_level_meter #(
      .channels(CH), .sample_width(SW), .indicator_width(IW),
      .section_sample_count(NS), .hold_sections(HS)
   ) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_channel(i_channel), .i_value(i_value),
      .o_valid(o_valid), .o_ready(o_ready), .o_array(o_array)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_max[c] = 0; m_cnt[c] = 0; m_bar[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
      end
   endtask

   task automatic model_accept(input int ch, input int v, output bit done);
      int mag;
      int lvl;
      done = 1'b0;
      if (ch < CH) begin
         mag = (v < 0) ? -v : v;
         if (mag > 32767) mag = 32767;
         if (mag > m_max[ch]) m_max[ch] = mag;
         m_cnt[ch]++;
         if (m_cnt[ch] == NS) begin
            m_cnt[ch] = 0;
            lvl = (m_max[ch] * IW) / 32768;
            if (lvl > IW) lvl = IW;
            if (lvl >= m_bar[ch]) m_bar[ch] = lvl;
            else                  m_bar[ch] = m_bar[ch] - 1;
            if (lvl >= m_peak[ch]) begin
               m_peak[ch] = lvl;
               m_hold[ch] = HS;
            end else if (m_hold[ch] > 0) begin
               m_hold[ch] = m_hold[ch] - 1;
            end else begin
               m_peak[ch] = (m_bar[ch] > m_peak[ch] - 1) ? m_bar[ch] : m_peak[ch] - 1;
            end
            m_max[ch] = 0;
            done = 1'b1;
         end
      end
   endtask

   function automatic logic [OW-1:0] exp_array();
      logic [OW-1:0] a;
      a = '0;
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < IW; k++)
            if ((k < m_bar[c]) || (m_peak[c] > 0 && k == m_peak[c] - 1))
               a[c*IW + k] = 1'b1;
      return a;
   endfunction

   task automatic do_reset();
      reset = 1'b1; i_valid = 1'b0; i_channel = '0; i_value = '0; o_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // Present one sample and hold it until accepted (bounded wait).
   task automatic send(input int ch, input int v, output bit done);
      int guard;
      guard = 0;
      i_valid = 1'b1; i_channel = 2'(ch); i_value = 16'(v);
      while (i_ready !== 1'b1 && guard < 8) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (guard >= 8) begin
         errors++;
         $display("FAIL send_accept: i_ready=%b after %0d cycles, required 1", i_ready, guard);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      model_accept(ch, v, done);
   endtask

   // A full section; when fixed the samples all equal pk, otherwise random
   // within +/-|pk| with pk itself placed at a random position.
   task automatic send_section(input int ch, input int pk, input bit fixed, output bit done);
      int pos;
      int v;
      int ap;
      ap  = (pk < 0) ? -pk : pk;
      pos = $urandom_range(0, NS - 1);
      done = 1'b0;
      for (int i = 0; i < NS; i++) begin
         if (fixed || i == pos) v = pk;
         else begin
            v = $urandom_range(0, ap);
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         send(ch, v, done);
      end
   endtask

   // Called right after the section-completing sample was accepted.
   task automatic check_section(input string tag);
      logic [OW-1:0] e;
      checks++;
      if (i_ready !== 1'b0) begin
         errors++; $display("FAIL %s stall: i_ready=%b required 0", tag, i_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL %s early_valid: o_valid=%b required 0", tag, o_valid);
      end
      checks++;
      if (i_ready !== 1'b1) begin
         errors++; $display("FAIL %s stall_len: i_ready=%b required 1", tag, i_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1) begin
         errors++; $display("FAIL %s valid: o_valid=%b required 1", tag, o_valid);
      end
      e = exp_array();
      checks++;
      if (o_array !== e) begin
         errors++; $display("FAIL %s array: got %h required %h", tag, o_array, e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; i_valid = 1'b0; i_channel = '0; i_value = '0; o_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", o_valid); end
      checks++;
      if (o_array !== '0) begin errors++; $display("FAIL reset_array: got %h required 0", o_array); end
      checks++;
      if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", i_ready); end
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
         errors++; $display("FAIL reset_idle: o_valid=%b i_ready=%b required 0/1", o_valid, i_ready);
      end
   endtask

   task automatic test_full_scale();
      bit done;
      do_reset();
      send_section(0, 32767, 1'b0, done);
      check_section("full_scale");
      checks++;
      if (o_array[31:0] !== 32'h7FFF_FFFF) begin
         errors++; $display("FAIL full_scale_ch0: got %h required 7fffffff", o_array[31:0]);
      end
      checks++;
      if (o_array[63:32] !== 32'h0) begin
         errors++; $display("FAIL full_scale_ch1: got %h required 0", o_array[63:32]);
      end
   endtask

   task automatic test_saturation();
      bit done;
      send_section(1, -32768, 1'b1, done);
      check_section("saturation");
      checks++;
      if (o_array[63:32] !== 32'h7FFF_FFFF) begin
         errors++; $display("FAIL saturation_ch1: got %h required 7fffffff", o_array[63:32]);
      end
      checks++;
      if (o_array[31:0] !== 32'h7FFF_FFFF) begin
         errors++; $display("FAIL saturation_ch0: got %h required 7fffffff", o_array[31:0]);
      end
   endtask

   task automatic test_decay_hold();
      bit done;
      logic [31:0] want;
      do_reset();
      send_section(0, 32767, 1'b1, done);
      check_section("decay_load");
      for (int k = 1; k <= 36; k++) begin
         send_section(0, 0, 1'b1, done);
         check_section("decay");
         want = 32'hx;
         if (k == 5)  want = 32'h43FF_FFFF;
         if (k == 32) want = 32'h4000_0000;
         if (k == 33) want = 32'h2000_0000;
         if (k == 34) want = 32'h1000_0000;
         if (k == 5 || k >= 32 && k <= 34) begin
            checks++;
            if (o_array[31:0] !== want) begin
               errors++; $display("FAIL decay_k%0d: got %h required %h", k, o_array[31:0], want);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit done;
      int nvalid;
      logic [OW-1:0] held;
      logic [OW-1:0] e;
      int chs [3] = '{1, 2, 0};
      int amp [3] = '{20000, 30000, 0};
      do_reset();
      o_ready = 1'b0;
      send_section(0, 32767, 1'b0, done);
      repeat (2) begin @(posedge clk); #1; end
      e = exp_array();
      checks++;
      if (o_valid !== 1'b1 || o_array !== e) begin
         errors++; $display("FAIL bp_first: valid=%b got %h required %h", o_valid, o_array, e);
      end
      held = o_array;
      for (int s = 0; s < 3; s++) begin
         send_section(chs[s], amp[s], amp[s] == 0, done);
         repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_array !== held) begin
               errors++; $display("FAIL bp_hold: valid=%b got %h required %h", o_valid, o_array, held);
            end
         end
      end
      o_ready = 1'b1;
      @(posedge clk); #1;
      e = exp_array();
      checks++;
      if (o_valid !== 1'b1 || o_array !== e) begin
         errors++; $display("FAIL bp_release: valid=%b got %h required %h", o_valid, o_array, e);
      end
      nvalid = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (o_valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 0) begin
         errors++; $display("FAIL bp_extra: %0d extra valid cycles, required 0", nvalid);
      end
   endtask

   task automatic test_illegal_and_reset();
      bit done;
      int nvalid;
      do_reset();
      for (int i = 0; i < NS - 1; i++) send(1, (i == 7) ? 5000 : $urandom_range(0, 4000), done);
      for (int i = 0; i < NS; i++) begin
         checks++;
         if (i_ready !== 1'b1) begin
            errors++; $display("FAIL illegal_ready: got %b required 1", i_ready);
         end
         send(3, -32768, done);
      end
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL illegal_valid: got %b required 0", o_valid); end
      send(1, 100, done);
      check_section("illegal");
      // Asynchronous reset with a held snapshot and a partial section in flight.
      o_ready = 1'b0;
      send_section(0, 32767, 1'b1, done);
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: o_valid=%b required 1", o_valid); end
      for (int i = 0; i < 10; i++) send(2, 31000, done);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b required 0", o_valid); end
      checks++;
      if (o_array !== '0) begin errors++; $display("FAIL areset_array: got %h required 0", o_array); end
      checks++;
      if (i_ready !== 1'b1) begin errors++; $display("FAIL areset_ready: got %b required 1", i_ready); end
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      o_ready = 1'b1;
      nvalid = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (o_valid === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 0) begin errors++; $display("FAIL areset_pending: %0d valid cycles, required 0", nvalid); end
      send_section(2, 25000, 1'b0, done);
      check_section("after_reset");
   endtask

   task automatic test_random();
      bit done;
      int ch;
      int v;
      logic signed [15:0] r;
      int sh [CH];
      do_reset();
      for (int c = 0; c < CH; c++) sh[c] = $urandom_range(0, 12);
      for (int n = 0; n < 1200; n++) begin
         ch = $urandom_range(0, 3);
         r  = 16'($urandom);
         r  = r >>> ((ch < CH) ? sh[ch] : 0);
         v  = int'(r);
         if ($urandom_range(0, 60) == 0) v = -32768;
         send(ch, v, done);
         if (done) begin
            check_section("random");
            sh[ch] = $urandom_range(0, 12);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_saturation();
      test_decay_hold();
      test_backpressure();
      test_illegal_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
